// File: rtl/alu.sv
// 32-bit MIPS32 integer ALU for the EX stage.
// Result, zero and signed-overflow flags are registered: valid one cycle after the inputs are sampled.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    input  logic             slt_op,
    input  logic             arith_op,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ov;
    logic             sub_ov;
    logic             lt_s;
    logic             lt_u;

    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;
    logic             ov_d;
    logic             ov_q;
    logic             zero_q;

    assign sum    = a + b;
    assign diff   = a - b;
    assign add_ov = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ov = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    // Direct compares, not the sign of the wrapped difference, so extreme operands stay correct.
    assign lt_s   = $signed(a) < $signed(b);
    assign lt_u   = a < b;

    always_comb begin
        y_d  = '0;
        ov_d = 1'b0;
        if (arith_op) begin
            case (op[1:0])
                2'b00: begin
                    y_d  = sum;
                    ov_d = add_ov;
                end
                2'b01: y_d = sum;
                2'b10: begin
                    if (slt_op) begin
                        y_d = {{(WIDTH-1){1'b0}}, lt_s};
                    end else begin
                        y_d  = diff;
                        ov_d = sub_ov;
                    end
                end
                default: begin
                    if (slt_op) y_d = {{(WIDTH-1){1'b0}}, lt_u};
                    else        y_d = diff;
                end
            endcase
        end else begin
            case (op)
                3'b000:  y_d = a & b;
                3'b001:  y_d = a | b;
                3'b010:  y_d = a ^ b;
                3'b011:  y_d = ~(a | b);
                3'b100:  y_d = b << shamt;
                3'b101:  y_d = b >> shamt;
                3'b110:  y_d = $signed(b) >>> shamt;
                default: y_d = {b[15:0], {(WIDTH-16){1'b0}}};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q    <= '0;
            zero_q <= 1'b1;
            ov_q   <= 1'b0;
        end else begin
            y_q    <= y_d;
            zero_q <= (y_d == '0);
            ov_q   <= ov_d;
        end
    end

    assign y        = y_q;
    assign zero     = zero_q;
    assign overflow = ov_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: reference model results queued at drive time, popped one cycle later.
module tb_alu;

    typedef struct {
        logic [31:0] y;
        logic        z;
        logic        ov;
        string       tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        slt_op;
    logic        arith_op;
    logic        zero;
    logic        overflow;
    logic [31:0] y;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_err;

    alu #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (op),
        .a        (a),
        .b        (b),
        .shamt    (shamt),
        .slt_op   (slt_op),
        .arith_op (arith_op),
        .zero     (zero),
        .overflow (overflow),
        .y        (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model built on 64-bit signed arithmetic: overflow means the true sum leaves the 32-bit range.
    function automatic exp_t ref_alu(input logic ar, input logic [2:0] o, input logic s,
                                     input logic [31:0] aa, input logic [31:0] bb,
                                     input logic [4:0] sh);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      full;
        logic [63:0] ext;
        sa   = longint'($signed(aa));
        sb   = longint'($signed(bb));
        full = 0;
        e.y  = '0;
        e.ov = 1'b0;
        if (ar) begin
            case (o[1:0])
                2'd0: begin
                    full = sa + sb;
                    e.y  = full[31:0];
                    e.ov = (full > 64'sd2147483647) || (full < -64'sd2147483648);
                end
                2'd1: e.y = aa + bb;
                2'd2: begin
                    if (s) begin
                        e.y = (sa < sb) ? 32'd1 : 32'd0;
                    end else begin
                        full = sa - sb;
                        e.y  = full[31:0];
                        e.ov = (full > 64'sd2147483647) || (full < -64'sd2147483648);
                    end
                end
                default: begin
                    if (s) e.y = ({32'd0, aa} < {32'd0, bb}) ? 32'd1 : 32'd0;
                    else   e.y = aa - bb;
                end
            endcase
        end else begin
            case (o)
                3'd0: e.y = aa & bb;
                3'd1: e.y = aa | bb;
                3'd2: e.y = aa ^ bb;
                3'd3: e.y = ~(aa | bb);
                3'd4: e.y = bb << sh;
                3'd5: e.y = bb >> sh;
                3'd6: begin
                    ext = {{32{bb[31]}}, bb} >> sh;
                    e.y = ext[31:0];
                end
                default: e.y = {bb[15:0], 16'h0000};
            endcase
        end
        e.z = (e.y == 32'd0);
        return e;
    endfunction

    task automatic collect();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, ".y"}, y, e.y);
            chk({e.tag, ".zero"}, {31'd0, zero}, {31'd0, e.z});
            chk({e.tag, ".ov"}, {31'd0, overflow}, {31'd0, e.ov});
        end
    endtask

    task automatic issue(input string tag, input logic ar, input logic [2:0] o, input logic s,
                         input logic [31:0] aa, input logic [31:0] bb, input logic [4:0] sh);
        exp_t e;
        @(negedge clk);
        arith_op = ar;
        op       = o;
        slt_op   = s;
        a        = aa;
        b        = bb;
        shamt    = sh;
        e        = ref_alu(ar, o, s, aa, bb, sh);
        e.tag    = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        collect();
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        op       = 3'd0;
        a        = '0;
        b        = '0;
        shamt    = '0;
        slt_op   = 1'b0;
        arith_op = 1'b0;

        // Reset held with inputs toggling
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            a        = $urandom;
            b        = $urandom;
            op       = 3'($urandom_range(0, 7));
            arith_op = 1'($urandom_range(0, 1));
            shamt    = 5'($urandom_range(0, 31));
            @(negedge clk);
            chk("rst.y", y, 32'd0);
            chk("rst.zero", {31'd0, zero}, 32'd1);
            chk("rst.ov", {31'd0, overflow}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        issue("add_5_7", 1'b1, 3'b000, 1'b0, 32'd5, 32'd7, 5'd0);
        chk("add_5_7.const", y, 32'd12);

        for (int i = 0; i < 128; i++) begin
            for (int j = 0; j < 128; j++) begin
                issue("slt_sweep", 1'b1, 3'b010, 1'b1, 32'(i), 32'(j), 5'd0);
            end
        end

        issue("slt_signed", 1'b1, 3'b010, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd0);
        chk("slt_signed.const", y, 32'd1);
        issue("sltu", 1'b1, 3'b011, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd0);
        chk("sltu.const", y, 32'd0);
        issue("slt_extreme", 1'b1, 3'b010, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 5'd0);
        chk("slt_extreme.const", y, 32'd1);

        issue("add_ov", 1'b1, 3'b000, 1'b0, 32'h7FFF_FFFF, 32'd1, 5'd0);
        chk("add_ov.const_y", y, 32'h8000_0000);
        chk("add_ov.const_ov", {31'd0, overflow}, 32'd1);
        issue("addu_noov", 1'b1, 3'b001, 1'b0, 32'h7FFF_FFFF, 32'd1, 5'd0);
        chk("addu_noov.const_ov", {31'd0, overflow}, 32'd0);
        issue("sub_ov", 1'b1, 3'b010, 1'b0, 32'h8000_0000, 32'd1, 5'd0);
        chk("sub_ov.const_y", y, 32'h7FFF_FFFF);
        chk("sub_ov.const_ov", {31'd0, overflow}, 32'd1);
        issue("sub_zero", 1'b1, 3'b010, 1'b0, 32'h1234, 32'h1234, 5'd0);
        chk("sub_zero.const_z", {31'd0, zero}, 32'd1);
        issue("add_op2_ignored", 1'b1, 3'b100, 1'b1, 32'h7FFF_FFFF, 32'd1, 5'd0);

        issue("sll", 1'b0, 3'b100, 1'b0, 32'd0, 32'h8000_0010, 5'd4);
        chk("sll.const", y, 32'h0000_0100);
        issue("srl", 1'b0, 3'b101, 1'b0, 32'd0, 32'h8000_0010, 5'd4);
        chk("srl.const", y, 32'h0800_0001);
        issue("sra", 1'b0, 3'b110, 1'b0, 32'd0, 32'h8000_0010, 5'd4);
        chk("sra.const", y, 32'hF800_0001);
        issue("sra_sh0", 1'b0, 3'b110, 1'b0, 32'd0, 32'h8000_0010, 5'd0);
        chk("sra_sh0.const", y, 32'h8000_0010);
        issue("and", 1'b0, 3'b000, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
        chk("and.const", y, 32'h00F0_00F0);
        issue("or", 1'b0, 3'b001, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
        issue("xor", 1'b0, 3'b010, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
        issue("nor", 1'b0, 3'b011, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0);
        chk("nor.const", y, 32'h000F_000F);

        for (int k = 0; k < 300; k++) begin
            issue("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)));
        end

        issue("lui", 1'b0, 3'b111, 1'b0, 32'h1111_1111, 32'h0000_ABCD, 5'd3);
        chk("lui.const", y, 32'hABCD_0000);

        // Reset between edges must clear outputs without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.y", y, 32'd0);
        chk("async_rst.zero", {31'd0, zero}, 32'd1);
        chk("async_rst.ov", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue("post_rst_add", 1'b1, 3'b000, 1'b0, 32'd40, 32'd2, 5'd0);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
